// File: rtl/spi_burst_ram_slave_pkg.sv
// Shared types and defaults for the burst-capable SPI RAM slave.
package spi_burst_ram_slave_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_MEM_DEPTH  = 256;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_DATA = 3'd5
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_burst_ram_slave_sp_ram.sv
// Single-port RAM with one-cycle synchronous read; array is not reset.
module spi_sp_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    if (re) dout <= mem[addr];
  end

endmodule

// File: rtl/spi_burst_ram_slave.sv
// SPI slave fronting an embedded RAM: command, address and data phases with
// optional auto-incrementing bursts while ss_n stays low.
module spi_burst_ram_slave
  import spi_burst_ram_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter bit          BURST_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic ss_n,
  input  logic mosi,
  output logic miso,
  output logic busy,
  output logic err
);

  localparam int unsigned SH_W  = max_u(max_u(DATA_WIDTH, ADDR_WIDTH), 2);
  localparam int unsigned CNT_W = $clog2(SH_W);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_t                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SH_W-2:0]       shift_q, shift_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  miso_d, busy_d, err_d;

  logic [SH_W-1:0]       shift_in;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0] word_in;
  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;

  // Incoming bit appended to everything received so far in this phase.
  assign shift_in = {shift_q, mosi};
  assign addr_in  = shift_in[ADDR_WIDTH-1:0];
  assign word_in  = shift_in[DATA_WIDTH-1:0];

  // Out-of-range payloads (non power-of-two depth) fold back into the array.
  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] ext;
    ext = {1'b0, a};
    if (ext >= DEPTH_X) return ADDR_WIDTH'(ext - DEPTH_X);
    return a;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] inc_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  spi_sp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .din  (word_in),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_WR_ADDR;
      cnt_q     <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      done_q    <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      miso      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      miso      <= miso_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

  // done_q marks a completed single-shot phase whose trailing bits are ignored.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done_d    = done_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    miso_d    = 1'b0;
    err_d     = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = wr_addr_q;

    if (ss_n) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      case (state_q)
        ST_CMD:                 err_d = 1'b1;
        ST_ADDR:                err_d = !done_q;
        ST_WR_DATA, ST_RD_DATA: err_d = !done_q && (cnt_q != '0);
        default:                err_d = 1'b0;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = '0;
          done_d  = 1'b0;
        end

        ST_CMD: begin
          shift_d = shift_in[SH_W-2:0];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            cnt_d = '0;
            cmd_d = cmd_t'(shift_in[1:0]);
            case (cmd_t'(shift_in[1:0]))
              CMD_WR_DATA: state_d = ST_WR_DATA;
              CMD_RD_DATA: state_d = ST_RD_WAIT;
              default:     state_d = ST_ADDR;
            endcase
          end
        end

        ST_ADDR: begin
          if (!done_q) begin
            shift_d = shift_in[SH_W-2:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
              cnt_d  = '0;
              done_d = 1'b1;
              if (cmd_q == CMD_RD_ADDR) rd_addr_d = wrap_addr(addr_in);
              else                      wr_addr_d = wrap_addr(addr_in);
            end
          end
        end

        ST_WR_DATA: begin
          if (!done_q) begin
            shift_d = shift_in[SH_W-2:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              cnt_d     = '0;
              ram_we    = 1'b1;
              wr_addr_d = inc_addr(wr_addr_q);
              if (!BURST_EN) done_d = 1'b1;
            end
          end
        end

        ST_RD_WAIT: begin
          ram_re   = 1'b1;
          ram_addr = rd_addr_q;
          state_d  = ST_RD_DATA;
          cnt_d    = '0;
        end

        ST_RD_DATA: begin
          // First bit comes straight from the RAM port, the rest from tx_q.
          if (!done_q) begin
            if (cnt_q == '0) begin
              miso_d = ram_dout[DATA_WIDTH-1];
              tx_d   = ram_dout << 1;
            end else begin
              miso_d = tx_q[DATA_WIDTH-1];
              tx_d   = tx_q << 1;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              cnt_d     = '0;
              rd_addr_d = inc_addr(rd_addr_q);
              if (BURST_EN) state_d = ST_RD_WAIT;
              else          done_d  = 1'b1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_spi_burst_ram_slave.sv
// Bench for spi_burst_ram_slave: a default burst instance and a 16-bit
// single-word instance, checked every cycle against a frame-level model.
module tb_spi_burst_ram_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ss_n_a = 1'b1, mosi_a = 1'b0, miso_a, busy_a, err_a;
  logic ss_n_b = 1'b1, mosi_b = 1'b0, miso_b, busy_b, err_b;

  always #5 clk = ~clk;

  spi_burst_ram_slave dut_a (
    .clk (clk), .rst (rst), .ss_n (ss_n_a), .mosi (mosi_a),
    .miso (miso_a), .busy (busy_a), .err (err_a)
  );

  spi_burst_ram_slave #(
    .DATA_WIDTH (16), .MEM_DEPTH (1024), .BURST_EN (1'b0)
  ) dut_b (
    .clk (clk), .rst (rst), .ss_n (ss_n_b), .mosi (mosi_b),
    .miso (miso_b), .busy (busy_b), .err (err_b)
  );

  typedef struct packed {
    logic [1:0] busy;
    logic [1:0] miso;
    logic [1:0] err;
  } exp_t;

  exp_t expq[$];
  bit   pay[$];
  int   checks = 0;
  int   errors = 0;
  int   err_a_seen = 0;

  // Model state per instance: 0 = default burst slave, 1 = 16-bit single-word slave.
  int          dw_m[2]    = '{8, 16};
  int          aw_m[2]    = '{8, 10};
  int          dep_m[2]   = '{256, 1024};
  bit          burst_m[2] = '{1'b1, 1'b0};
  int          wa_m[2]    = '{0, 0};
  int          ra_m[2]    = '{0, 0};
  logic [15:0] mem_m [2][1024];

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check_bit("busy_a", busy_a, e.busy[0]);
      check_bit("miso_a", miso_a, e.miso[0]);
      check_bit("err_a",  err_a,  e.err[0]);
      check_bit("busy_b", busy_b, e.busy[1]);
      check_bit("miso_b", miso_b, e.miso[1]);
      check_bit("err_b",  err_b,  e.err[1]);
      if (err_a === 1'b1) err_a_seen++;
    end
  end

  // One clock: drive inputs for the coming edge and queue the outputs it must produce.
  task automatic cycle(input int sel, input logic ss, input logic mo, input logic r,
                       input logic eb, input logic em, input logic ee);
    exp_t e;
    @(negedge clk);
    rst    = r;
    ss_n_a = 1'b1; mosi_a = 1'b0;
    ss_n_b = 1'b1; mosi_b = 1'b0;
    if (sel == 0) begin ss_n_a = ss; mosi_a = mo; end
    else          begin ss_n_b = ss; mosi_b = mo; end
    e = '0;
    e.busy[sel] = eb;
    e.miso[sel] = em;
    e.err[sel]  = ee;
    expq.push_back(e);
  endtask

  task automatic put(input logic [31:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) pay.push_back(v[i]);
  endtask

  task automatic pad(input int n);
    for (int i = 0; i < n; i++) pay.push_back(1'b0);
  endtask

  // Full frame: select edge, two command bits, payload from pay[], deselect, idle.
  task automatic frame(input int sel, input logic [1:0] cmd);
    int dw, aw, dep, n, cnt, lastk, w, k;
    logic [31:0] v;
    logic ev, dn, m;
    dw = dw_m[sel]; aw = aw_m[sel]; dep = dep_m[sel];
    n = pay.size(); cnt = 0; v = '0; ev = 1'b0; dn = 1'b0;
    cycle(sel, 1'b0, 1'b0,   1'b0, 1'b1, 1'b0, 1'b0);
    cycle(sel, 1'b0, cmd[1], 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(sel, 1'b0, cmd[0], 1'b0, 1'b1, 1'b0, 1'b0);
    if (cmd == 2'b11) begin
      // Each word occupies dw+1 edges: a zero lead-in, then dw bits MSB first.
      for (int j = 0; j < n; j++) begin
        if (burst_m[sel]) begin w = j / (dw + 1); k = j % (dw + 1); end
        else begin w = 0; k = j; end
        m = 1'b0;
        if (k >= 1 && k <= dw) begin
          v = {16'h0, mem_m[sel][(ra_m[sel] + w) % dep]};
          m = v[dw - k];
        end
        cycle(sel, 1'b0, pay[j], 1'b0, 1'b1, m, 1'b0);
      end
      if (burst_m[sel]) ra_m[sel] = (ra_m[sel] + n / (dw + 1)) % dep;
      else if (n > dw)  ra_m[sel] = (ra_m[sel] + 1) % dep;
      lastk = burst_m[sel] ? (n - 1) % (dw + 1) : n - 1;
      ev = (n > 0) && (lastk >= 1) && (lastk < dw);
    end else begin
      for (int j = 0; j < n; j++) begin
        cycle(sel, 1'b0, pay[j], 1'b0, 1'b1, 1'b0, 1'b0);
        if (!dn) begin
          v = {v[30:0], pay[j]};
          cnt++;
          if (cmd[0] == 1'b0 && cnt == aw) begin
            dn = 1'b1;
            if (cmd[1]) ra_m[sel] = int'(v) % dep;
            else        wa_m[sel] = int'(v) % dep;
          end
          if (cmd == 2'b01 && cnt == dw) begin
            mem_m[sel][wa_m[sel]] = v[15:0];
            wa_m[sel] = (wa_m[sel] + 1) % dep;
            cnt = 0; v = '0;
            if (!burst_m[sel]) dn = 1'b1;
          end
        end
      end
      ev = (cmd[0] == 1'b0) ? !dn : (cnt != 0);
    end
    cycle(sel, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ev);
    cycle(sel, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pay.delete();
  endtask

  task automatic wr_word(input int sel, input int addr, input logic [31:0] d);
    put(addr, aw_m[sel]); frame(sel, 2'b00);
    put(d, dw_m[sel]);    frame(sel, 2'b01);
  endtask

  task automatic rd_word(input int sel, input int addr);
    put(addr, aw_m[sel]);  frame(sel, 2'b10);
    pad(dw_m[sel] + 1);    frame(sel, 2'b11);
  endtask

  initial begin
    int seen0;

    // Reset state held for two edges, then released.
    cycle(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single write / read of 0xA5 at 0x10.
    wr_word(0, 'h10, 'hA5);
    rd_word(0, 'h10);
    check_int("pin_mem_10", int'(mem_m[0]['h10]), 'hA5);
    check_int("pin_ra_after_read", ra_m[0], 'h11);
    check_int("err_quiet_basic", err_a_seen, 0);

    // Burst write across the top of the array, then burst read back.
    put('hFE, 8); frame(0, 2'b00);
    put('h11, 8); put('h22, 8); put('h33, 8); frame(0, 2'b01);
    check_int("pin_mem_fe", int'(mem_m[0]['hFE]), 'h11);
    check_int("pin_mem_ff", int'(mem_m[0]['hFF]), 'h22);
    check_int("pin_mem_00", int'(mem_m[0][0]), 'h33);
    check_int("pin_wa_wrap", wa_m[0], 1);
    put('hFE, 8); frame(0, 2'b10);
    pad(27); frame(0, 2'b11);

    // Frame dropped after 5 of 8 data bits; next frame lands at the same address.
    put('h40, 8); frame(0, 2'b00);
    seen0 = err_a_seen;
    put('h1F, 5); frame(0, 2'b01);
    check_int("err_pulse_once", err_a_seen - seen0, 1);
    put('h5A, 8); frame(0, 2'b01);
    check_int("pin_mem_40", int'(mem_m[0]['h40]), 'h5A);
    rd_word(0, 'h40);

    // Reset during the sixth data bit of a write frame.
    wr_word(0, 'h20, 'h77);
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wa_m = '{0, 0};
    ra_m = '{0, 0};
    pad(9); frame(0, 2'b11);
    rd_word(0, 'h20);
    put('hC3, 8); frame(0, 2'b01);
    rd_word(0, 'h00);

    // 16-bit single-word slave: extra word in the frame is ignored.
    put('h3FF, 10); frame(1, 2'b00);
    put('hBEEF, 16); put('h1234, 16); frame(1, 2'b01);
    check_int("pin_b_mem_3ff", int'(mem_m[1]['h3FF]), 'hBEEF);
    check_int("pin_b_wa_wrap", wa_m[1], 0);
    put('h3FF, 10); frame(1, 2'b10);
    pad(21); frame(1, 2'b11);
    put('h0001, 16); frame(1, 2'b01);
    rd_word(1, 'h000);

    // All-zero / all-one words at both ends of each array.
    wr_word(0, 'h00, 'h00);
    wr_word(0, 'hFF, 'hFF);
    rd_word(0, 'h00);
    rd_word(0, 'hFF);
    put('hFF, 8); frame(0, 2'b00);
    put('h00, 8); put('hFF, 8); frame(0, 2'b01);
    put('hFF, 8); frame(0, 2'b10);
    pad(18); frame(0, 2'b11);
    wr_word(1, 'h000, 'hFFFF);
    wr_word(1, 'h3FF, 'h0000);
    rd_word(1, 'h000);
    rd_word(1, 'h3FF);

    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_burst_ram_slave.md
# spi_burst_ram_slave

Parametrised SPI slave with an embedded single-port RAM. Generalises the 8-bit/256-entry SPI-RAM slave to arbitrary data width and depth and adds burst mode: after one address phase, consecutive words are written or read with address auto-increment while `ss_n` stays low. Sits at the chip's serial configuration boundary; the SPI bit clock equals `clk`.

## Interface
- `DATA_WIDTH`, 8, RAM word width and SPI data payload width
- `MEM_DEPTH`, 256, number of RAM words, ≥ 2
- `ADDR_WIDTH`, `$clog2(MEM_DEPTH)`, address payload width
- `BURST_EN`, 1, 1 enables auto-increment bursts; 0 ends every frame after one word
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ss_n`  in  1  slave select, active low
- `mosi`  in  1  serial data in, MSB first, sampled on rising `clk`
- `miso`  out  1  serial data out, MSB first
- `busy`  out  1  high in every state except IDLE
- `err`  out  1  one-cycle pulse on aborted frame

## Operation
- Commands `cmd[1:0]`:
  - 00: write address, latches `wr_addr`
  - 01: write data, writes to `wr_addr`
  - 10: read address, latches `rd_addr`
  - 11: read data, returns `mem[rd_addr]`
- `wr_addr` and `rd_addr` are independent registers.
- States:
  - IDLE
  - CMD: 2 bits
  - ADDR: ADDR_WIDTH bits
  - WR_DATA: DATA_WIDTH bits per word
  - RD_WAIT: 1 cycle
  - RD_DATA: DATA_WIDTH bits per word
- Transitions:
  - IDLE→CMD on first edge with `ss_n`=0; nothing is sampled on that edge.
  - CMD→ADDR for 00/10, →WR_DATA for 01, →RD_WAIT for 11.
  - ADDR: after the last address bit, latches the target address register, then waits in ADDR (ignoring `mosi`) until `ss_n`=1 → IDLE.
  - WR_DATA: on the last bit, RAM write of the assembled word at `wr_addr`, then `wr_addr` ← `wr_addr`+1.
    - BURST_EN=1: remain in WR_DATA for the next word.
    - BURST_EN=0: ignore further bits until `ss_n`=1.
  - RD_WAIT: issue RAM read at `rd_addr` (1-cycle synchronous read), then → RD_DATA.
  - RD_DATA: after the last bit, `rd_addr` ← `rd_addr`+1.
    - BURST_EN=1: → RD_WAIT.
    - BURST_EN=0: hold `miso`=0 until `ss_n`=1.
- Any state, `ss_n`=1 → IDLE next edge.
  - If this happens mid-command, mid-address or mid-word: partial bits discarded, no RAM write, no address update, `err`=1 for one cycle.
  - At a word boundary or after a completed address phase: no error.
- Address increment wraps from MEM_DEPTH-1 to 0 in both address registers.
  - For non-power-of-2 depth, an address payload ≥ MEM_DEPTH is reduced modulo MEM_DEPTH when latched.

## Timing
- Reset values:
  - `miso`=0, `busy`=0, `err`=0
  - state IDLE, `wr_addr`=`rd_addr`=0, bit counter 0
  - RAM contents not reset
- Reset asserted mid-frame: immediate return to reset values. The frame is lost, no write occurs, and the slave waits for a fresh `ss_n` falling edge.
- Frame latency, counted from the edge where IDLE first sees `ss_n`=0 (edge 0):
  - cmd bits on edges 1–2
  - first payload bit on edge 3
  - write commits on edge 2+DATA_WIDTH
- Read: `miso` carries data MSB on the cycle after RD_WAIT and holds each bit for one cycle. `miso`=0 in all non-RD_DATA states.
- Burst read has exactly one gap cycle (RD_WAIT, `miso`=0) between words. Burst write has no gap.
- `busy` registered, follows state.

## Structure
- Shared package holds:
  - default width/depth constants
  - `cmd_t` enum (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA)
  - `state_t` enum
- Sub-module `spi_sp_ram`: parametrised single-port RAM with `we`, `re`, `addr`, `din`, `dout`, 1-cycle synchronous read. No reset on the array.
- Top holds FSM, shift register, bit counter and address registers.

## Test plan
- Default params, frame 00+0x10, then frame 01+0xA5; frame 10+0x10, then frame 11 → `miso` shifts 1010_0101 starting edge 4; `err` never pulses.
- Burst write: 00+0xFE, then 01+0x11,0x22,0x33 in one frame → mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 (wrap). Burst read from 0xFE returns the same three words with one 0 gap cycle between each.
- `ss_n` raised after 5 of 8 data bits → no RAM write, `wr_addr` unchanged, `err` high exactly one cycle, next frame works normally.
- `rst` pulsed during WR_DATA bit 6 → `busy`=0, `miso`=0, both addresses 0; previously written RAM words still readable.
- DATA_WIDTH=16, MEM_DEPTH=1024, BURST_EN=0: write 0xBEEF at 0x3FF, then a second word in the same frame → only 0xBEEF stored, `wr_addr`=0x000 after wrap. Read-back returns 0xBEEF, then `miso`=0.
- Max/min patterns: write 0x00 and 0xFF at addresses 0 and MEM_DEPTH-1 → exact read-back.
